// File: rtl/acc_bank_if.sv
// Beat-in / snapshot-out bus of the accumulator bank.
// The bank side uses the slave modport and the array/consumer side uses master.
interface acc_bank_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned DEPTH  = 8
);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  logic                   clear;
  logic                   in_valid;
  logic                   in_ready;
  logic [DATA_W-1:0]      in_data;
  logic                   in_first;
  logic                   in_final;
  logic [IDX_W-1:0]       wr_idx;
  logic                   out_valid;
  logic                   out_ready;
  logic [DEPTH*ACC_W-1:0] acc_out;
  logic                   out_sat;
  logic                   full;

  modport master (
    output clear, in_valid, in_data, in_first, in_final, out_ready,
    input  in_ready, wr_idx, out_valid, acc_out, out_sat, full
  );

  modport slave (
    input  clear, in_valid, in_data, in_first, in_final, out_ready,
    output in_ready, wr_idx, out_valid, acc_out, out_sat, full
  );
endinterface

// File: rtl/acc_bank.sv
// Output accumulator bank: overwrites or saturating-accumulates DEPTH beats per pass
// and presents a snapshot of all slots after the final pass.
module acc_bank #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ACC_W  = 16,
  parameter int unsigned DEPTH  = 8
) (
  input  logic        clk,
  input  logic        reset,
  acc_bank_if.slave   bus
);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        wr_idx_q, wr_idx_d;
  logic signed [ACC_W-1:0] slot_q [DEPTH];
  logic signed [ACC_W-1:0] slot_d [DEPTH];
  logic [DEPTH*ACC_W-1:0]  acc_out_q, acc_out_d;
  logic                    out_valid_q, out_valid_d;
  logic                    out_sat_q, out_sat_d;
  logic                    sticky_q, sticky_d;

  logic                    accept, last_slot, snapshot, clamp;
  logic signed [ACC_W-1:0] beat_ext, beat_val;
  logic signed [ACC_W:0]   sum;

  // New slot value for the beat on the bus: overwrite or saturating add.
  always_comb begin
    beat_ext = ACC_W'(signed'(bus.in_data));
    sum      = (ACC_W+1)'(slot_q[wr_idx_q]) + (ACC_W+1)'(beat_ext);
    clamp    = 1'b0;
    beat_val = beat_ext;
    if (!bus.in_first) begin
      beat_val = sum[ACC_W-1:0];
      if (sum[ACC_W] != sum[ACC_W-1]) begin
        clamp    = 1'b1;
        beat_val = sum[ACC_W] ? ACC_MIN : ACC_MAX;
      end
    end
  end

  // Next-state and control.
  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    sticky_d    = sticky_q;
    out_sat_d   = out_sat_q;
    accept      = bus.in_valid && (state_q == FILL) && !bus.clear;
    last_slot   = (wr_idx_q == IDX_W'(DEPTH-1));
    snapshot    = accept && last_slot && bus.in_final;

    if (bus.clear) begin
      state_d   = FILL;
      wr_idx_d  = '0;
      sticky_d  = 1'b0;
      out_sat_d = 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (accept) begin
            wr_idx_d = last_slot ? '0 : wr_idx_q + IDX_W'(1);
            sticky_d = sticky_q | clamp;
            if (snapshot) begin
              state_d   = HOLD;
              out_sat_d = sticky_q | clamp;
              sticky_d  = 1'b0;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) state_d = FILL;
        end
        default: state_d = FILL;
      endcase
    end
    out_valid_d = (state_d == HOLD);
  end

  // Slot array update and snapshot packing (snapshot includes the final beat).
  always_comb begin
    for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = slot_q[i];
    if (bus.clear) begin
      for (int i = 0; i < int'(DEPTH); i++) slot_d[i] = '0;
    end else if (accept) begin
      slot_d[wr_idx_q] = beat_val;
    end
    acc_out_d = acc_out_q;
    if (snapshot) begin
      for (int i = 0; i < int'(DEPTH); i++) acc_out_d[i*ACC_W +: ACC_W] = slot_d[i];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx_q    <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      out_sat_q   <= 1'b0;
      sticky_q    <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= '0;
    end else begin
      wr_idx_q    <= wr_idx_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      out_sat_q   <= out_sat_d;
      sticky_q    <= sticky_d;
      for (int i = 0; i < int'(DEPTH); i++) slot_q[i] <= slot_d[i];
    end
  end

  assign bus.in_ready  = (state_q == FILL);
  assign bus.wr_idx    = wr_idx_q;
  assign bus.out_valid = out_valid_q;
  assign bus.full      = out_valid_q;
  assign bus.acc_out   = acc_out_q;
  assign bus.out_sat   = out_sat_q;
endmodule

// File: tb/tb_acc_bank.sv
// Self-checking bench for acc_bank: directed scenarios plus random traffic
// compared cycle by cycle against an integer model of the bank.
module tb_acc_bank;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int D  = 8;
  localparam int AMAX = (1 <<< (AW-1)) - 1;
  localparam int AMIN = -(1 <<< (AW-1));

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  acc_bank_if #(.DATA_W(DW), .ACC_W(AW), .DEPTH(D)) bus ();

  acc_bank #(.DATA_W(DW), .ACC_W(AW), .DEPTH(D)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  int m_slot [D];
  int m_snap [D];
  int m_idx;
  bit m_hold, m_sticky, m_osat;
  int raw [D];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int sat_add(input int a, input int b, output bit f);
    int s;
    s = a + b;
    f = 1'b0;
    if (s > AMAX) begin s = AMAX; f = 1'b1; end
    if (s < AMIN) begin s = AMIN; f = 1'b1; end
    return s;
  endfunction

  function automatic logic [D*AW-1:0] snap_vec();
    logic [D*AW-1:0] v;
    for (int i = 0; i < D; i++) v[i*AW +: AW] = AW'(m_snap[i]);
    return v;
  endfunction

  function automatic int slot_of(input int i);
    logic signed [AW-1:0] s;
    s = bus.acc_out[i*AW +: AW];
    return int'(s);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < D; i++) begin m_slot[i] = 0; m_snap[i] = 0; end
    m_idx = 0; m_hold = 0; m_sticky = 0; m_osat = 0;
  endtask

  // Effect of the upcoming clock edge given the inputs currently on the bus.
  task automatic model_step();
    int d, v;
    bit f;
    if (bus.clear) begin
      for (int i = 0; i < D; i++) m_slot[i] = 0;
      m_idx = 0; m_sticky = 0; m_hold = 0; m_osat = 0;
    end else if (!m_hold) begin
      if (bus.in_valid) begin
        d = int'($signed(bus.in_data));
        f = 1'b0;
        if (bus.in_first) v = d;
        else v = sat_add(m_slot[m_idx], d, f);
        m_slot[m_idx] = v;
        m_sticky = m_sticky | f;
        if (m_idx == D-1) begin
          m_idx = 0;
          if (bus.in_final) begin
            m_snap = m_slot;
            m_osat = m_sticky;
            m_sticky = 0;
            m_hold = 1;
          end
        end else begin
          m_idx++;
        end
      end
    end else if (bus.out_ready) begin
      m_hold = 0;
    end
  endtask

  task automatic check_all();
    chk("in_ready",  bus.in_ready,  !m_hold);
    chk("wr_idx",    bus.wr_idx,    m_idx);
    chk("out_valid", bus.out_valid, m_hold);
    chk("full",      bus.full,      m_hold);
    chk("out_sat",   bus.out_sat,   m_osat);
    chk("acc_out",   bus.acc_out,   snap_vec());
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic beat(input int data, input bit first, input bit fin);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(data);
    bus.in_first = first;
    bus.in_final = fin;
    cycle();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    cycle();
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    bus.in_valid = 1'b0;
    cycle();
    bus.clear = 1'b0;
  endtask

  task automatic release_snapshot();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int pd [3];
    logic signed [DW-1:0] r;
    reset         = 1'b0;
    bus.clear     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_first  = 1'b0;
    bus.in_final  = 1'b0;
    bus.out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    chk("reset_acc_out", bus.acc_out, 0);
    reset = 1'b1;
    idle();

    // Single pass with data 1..8, then back-pressure while a beat waits.
    for (int k = 0; k < D; k++) beat(k + 1, 1'b1, k == D-1);
    chk("single_valid", bus.out_valid, 1);
    for (int k = 0; k < D; k++) chk("single_slot", slot_of(k), k + 1);
    chk("single_sat", bus.out_sat, 0);
    for (int c = 0; c < 5; c++) beat(77, 1'b1, 1'b0);
    chk("bp_in_ready", bus.in_ready, 0);
    chk("bp_wr_idx", bus.wr_idx, 0);
    bus.out_ready = 1'b1;
    cycle();
    bus.out_ready = 1'b0;
    chk("bp_valid_fell", bus.out_valid, 0);
    beat(77, 1'b1, 1'b0);
    chk("bp_first_accept", bus.wr_idx, 1);
    do_clear();

    // Three passes: 10, then -3, then +5 with final on the last.
    pd[0] = 10; pd[1] = -3; pd[2] = 5;
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < D; k++) beat(pd[p], p == 0, (p == 2) && (k == D-1));
      if (p < 2) chk("no_early_valid", bus.out_valid, 0);
    end
    for (int k = 0; k < D; k++) chk("three_pass_slot", slot_of(k), 12);
    release_snapshot();

    // Positive and negative saturation on slot 0.
    for (int s = 0; s < 2; s++) begin
      for (int k = 0; k < D; k++) beat(k == 0 ? (s == 0 ? 32760 : -32760) : 0, 1'b1, 1'b0);
      for (int k = 0; k < D; k++) beat(k == 0 ? (s == 0 ? 100 : -100) : 0, 1'b0, k == D-1);
      chk("sat_slot0", slot_of(0), s == 0 ? 32767 : -32768);
      chk("sat_flag", bus.out_sat, 1);
      release_snapshot();
    end

    // Clear mid-tile with a beat presented, then accumulate onto zeroed slots.
    for (int k = 0; k < 4; k++) beat(int'($urandom_range(1, 1000)), 1'b1, 1'b0);
    bus.clear = 1'b1;
    beat(999, 1'b1, 1'b0);
    bus.clear = 1'b0;
    chk("clear_wr_idx", bus.wr_idx, 0);
    for (int k = 0; k < D; k++) begin
      r = DW'($urandom);
      raw[k] = int'(r);
      beat(raw[k], 1'b0, k == D-1);
    end
    for (int k = 0; k < D; k++) chk("clear_raw_slot", slot_of(k), raw[k]);
    chk("clear_sat", bus.out_sat, 0);
    release_snapshot();

    // Random traffic: gaps, mixed first/final, stalls and occasional clears.
    for (int c = 0; c < 400; c++) begin
      r = ($urandom_range(0, 3) == 0) ? DW'($urandom) : DW'($urandom_range(0, 400) - 200);
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = r;
      bus.in_first  = ($urandom_range(0, 3) == 0);
      bus.in_final  = ($urandom_range(0, 1) == 0);
      bus.out_ready = ($urandom_range(0, 1) == 0);
      bus.clear     = ($urandom_range(0, 40) == 0);
      cycle();
    end
    bus.clear = 1'b0;
    bus.out_ready = 1'b0;
    do_clear();

    // Asynchronous reset while a snapshot is held.
    for (int k = 0; k < D; k++) beat(k * 3, 1'b1, k == D-1);
    idle();
    chk("hold_before_reset", bus.out_valid, 1);
    #3;
    reset = 1'b0;
    #1;
    model_reset();
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_full", bus.full, 0);
    chk("async_in_ready", bus.in_ready, 1);
    chk("async_wr_idx", bus.wr_idx, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    check_all();
    for (int k = 0; k < D; k++) beat(-k, 1'b0, k == D-1);
    release_snapshot();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
